// File: rtl/condicionador_entrada.sv
// condicionador_entrada
//   Conditions a bouncing push-button and a 4-bit digit switch bank for the
//   downstream track-state FSM. Both inputs are brought into the clk domain
//   by 2-flop synchronizers. The button is then debounced by a four-state
//   FSM. Each accepted press produces a single-cycle pulse and captures the
//   digit.
//
//   Parameters
//     DEBOUNCE_CICLOS  consecutive synchronized samples needed to accept a
//                      press or a release (2..65535, default 16)
//
//   Ports
//     clk            in   single clock, rising edge
//     reset          in   asynchronous, active-high reset
//     botao_insere   in   raw bouncing push-button (asynchronous)
//     chaves_numero  in   raw digit switches (asynchronous)
//     insere         out  one-cycle pulse per accepted press
//     numero         out  digit captured at the accepted press
//     ocupado        out  high while the FSM is away from OCIOSO
//     erro_bcd       out  a non-BCD digit was rejected at the last accept
//
//   Optional feature
//     CONDICIONADOR_FILTRO_BCD_EN  when defined, an accept whose digit is
//     greater than 9 gives no pulse and leaves numero unchanged. It sets
//     erro_bcd instead, and erro_bcd stays set until the next valid accept.
//     When undefined, every digit is accepted and erro_bcd is tied low.

module condicionador_entrada #(
    parameter int unsigned DEBOUNCE_CICLOS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao_insere,
    input  logic [3:0] chaves_numero,
    output logic       insere,
    output logic [3:0] numero,
    output logic       ocupado,
    output logic       erro_bcd
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        FILTRA_PRESS,
        PRESSIONADO,
        FILTRA_SOLTA
    } estado_t;

    estado_t       r_estado;
    estado_t       w_prox_estado;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_prox_cnt;
    logic          w_aceita;

    logic          r_botao_meta;
    logic          r_botao_s;
    logic [3:0]    r_chaves_meta;
    logic [3:0]    r_chaves_s;

    logic          r_insere;
    logic          w_prox_insere;
    logic [3:0]    r_numero;
    logic [3:0]    w_prox_numero;

    // Synchronizers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_botao_meta  <= 1'b0;
            r_botao_s     <= 1'b0;
            r_chaves_meta <= '0;
            r_chaves_s    <= '0;
        end else begin
            r_botao_meta  <= botao_insere;
            r_botao_s     <= r_botao_meta;
            r_chaves_meta <= chaves_numero;
            r_chaves_s    <= r_chaves_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_prox_estado;
            r_cnt    <= w_prox_cnt;
        end
    end

    // Next state. The sample that leaves OCIOSO or PRESSIONADO is not
    // counted. The filter states then need DEBOUNCE_CICLOS further agreeing
    // samples, counted from 0 up to DEBOUNCE_CICLOS-1.
    always_comb begin
        w_prox_estado = r_estado;
        w_prox_cnt    = r_cnt;
        w_aceita      = 1'b0;
        unique case (r_estado)
            OCIOSO: begin
                if (r_botao_s) begin
                    w_prox_estado = FILTRA_PRESS;
                    w_prox_cnt    = '0;
                end
            end
            FILTRA_PRESS: begin
                if (!r_botao_s) begin
                    w_prox_estado = OCIOSO;
                    w_prox_cnt    = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_prox_estado = PRESSIONADO;
                    w_prox_cnt    = '0;
                    w_aceita      = 1'b1;
                end else begin
                    w_prox_cnt    = r_cnt + CW'(1);
                end
            end
            PRESSIONADO: begin
                if (!r_botao_s) begin
                    w_prox_estado = FILTRA_SOLTA;
                    w_prox_cnt    = '0;
                end
            end
            FILTRA_SOLTA: begin
                if (r_botao_s) begin
                    w_prox_estado = PRESSIONADO;
                    w_prox_cnt    = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_prox_estado = OCIOSO;
                    w_prox_cnt    = '0;
                end else begin
                    w_prox_cnt    = r_cnt + CW'(1);
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
                w_prox_cnt    = '0;
            end
        endcase
    end

`ifdef CONDICIONADOR_FILTRO_BCD_EN
    logic r_erro;
    logic w_prox_erro;

    // Accept handling with the BCD filter. A rejected digit still moves the
    // FSM to PRESSIONADO, so the held button gives no retry pulse.
    always_comb begin
        w_prox_insere = 1'b0;
        w_prox_numero = r_numero;
        w_prox_erro   = r_erro;
        if (w_aceita) begin
            if (r_chaves_s > 4'd9) begin
                w_prox_erro   = 1'b1;
            end else begin
                w_prox_insere = 1'b1;
                w_prox_numero = r_chaves_s;
                w_prox_erro   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= w_prox_erro;
        end
    end

    assign erro_bcd = r_erro;
`else
    always_comb begin
        w_prox_insere = 1'b0;
        w_prox_numero = r_numero;
        if (w_aceita) begin
            w_prox_insere = 1'b1;
            w_prox_numero = r_chaves_s;
        end
    end

    assign erro_bcd = 1'b0;
`endif

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_insere <= 1'b0;
            r_numero <= '0;
        end else begin
            r_insere <= w_prox_insere;
            r_numero <= w_prox_numero;
        end
    end

    assign insere  = r_insere;
    assign numero  = r_numero;
    assign ocupado = (r_estado != OCIOSO);

endmodule

// File: tb/tb_condicionador_entrada.sv
module tb_condicionador_entrada;

    localparam int D = 4;
`ifdef CONDICIONADOR_FILTRO_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       botao_insere;
    logic [3:0] chaves_numero;
    logic       insere;
    logic [3:0] numero;
    logic       ocupado;
    logic       erro_bcd;

    always #5 clk = ~clk;

    condicionador_entrada #(.DEBOUNCE_CICLOS(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .botao_insere  (botao_insere),
        .chaves_numero (chaves_numero),
        .insere        (insere),
        .numero        (numero),
        .ocupado       (ocupado),
        .erro_bcd      (erro_bcd)
    );

    // Reference model. The debounced level flips once the synchronized
    // button has disagreed with it for D+1 consecutive samples.
    bit         m_s1, m_s2;
    logic [3:0] m_c1, m_c2;
    bit         m_deb;
    int         m_run;
    logic       m_ins;
    logic [3:0] m_num;
    logic       m_err;

    int n_vec  = 0;
    int n_fail = 0;
    int pulses = 0;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_c1 = '0; m_c2 = '0;
        m_deb = 0; m_run = 0; m_ins = 0; m_num = '0; m_err = 0;
    endtask

    task automatic model_edge();
        bit         bs;
        logic [3:0] cs;
        bs = m_s2;
        cs = m_c2;
        m_s2 = m_s1; m_s1 = botao_insere;
        m_c2 = m_c1; m_c1 = chaves_numero;
        m_ins = 0;
        if (bs != m_deb) begin
            m_run++;
            if (m_run == D + 1) begin
                m_deb = bs;
                m_run = 0;
                if (m_deb) begin
                    if (BCD && cs > 9) begin
                        m_err = 1;
                    end else begin
                        m_ins = 1;
                        m_num = cs;
                        m_err = 0;
                    end
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check(input string tag);
        logic exp_ocu;
        exp_ocu = m_deb || (m_run > 0);
        n_vec++;
        assert (insere === m_ins) else begin
            n_fail++;
            $error("FAIL %s insere got %b exp %b", tag, insere, m_ins);
        end
        n_vec++;
        assert (numero === m_num) else begin
            n_fail++;
            $error("FAIL %s numero got %0d exp %0d", tag, numero, m_num);
        end
        n_vec++;
        assert (ocupado === exp_ocu) else begin
            n_fail++;
            $error("FAIL %s ocupado got %b exp %b", tag, ocupado, exp_ocu);
        end
        n_vec++;
        assert (erro_bcd === m_err) else begin
            n_fail++;
            $error("FAIL %s erro_bcd got %b exp %b", tag, erro_bcd, m_err);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check(tag);
        if (insere === 1'b1) pulses++;
    endtask

    task automatic drive(input bit b, input logic [3:0] c, input int n, input string tag);
        botao_insere  = b;
        chaves_numero = c;
        repeat (n) step(tag);
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_vec++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic async_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check(tag);
    endtask

    initial begin
        int first;
        reset = 1'b1;
        botao_insere = 1'b0;
        chaves_numero = '0;
        #1;
        model_reset();
        check("reset");
        repeat (3) step("reset_hold");
        reset = 1'b0;

        // Clean press: one pulse after edge 7, no auto-repeat
        pulses = 0; first = 0;
        botao_insere = 1'b1; chaves_numero = 4'd5;
        for (int k = 1; k <= 20; k++) begin
            step("press5");
            if (insere === 1'b1 && first == 0) first = k;
        end
        check_int("press5_edge", first, 7);
        check_int("press5_pulses", pulses, 1);
        check_int("press5_numero", int'(numero), 5);
        drive(0, 4'd5, 10, "rel5");

        // Short glitch is rejected
        pulses = 0;
        drive(1, 4'd8, 3, "glitch");
        drive(0, 4'd8, 10, "glitch_low");
        check_int("glitch_pulses", pulses, 0);
        check_int("glitch_ocupado", int'(ocupado), 0);
        check_int("glitch_numero", int'(numero), 5);

        // Release bounce, then a clean press
        pulses = 0;
        drive(1, 4'd2, 10, "b_press");
        drive(0, 4'd2, 2, "b_low2");
        drive(1, 4'd2, 1, "b_high1");
        drive(0, 4'd2, 10, "b_low10");
        drive(1, 4'd6, 10, "b_press6");
        drive(0, 4'd6, 10, "b_rel6");
        check_int("bounce_pulses", pulses, 2);
        check_int("bounce_numero", int'(numero), 6);

        // Switch changes while held are ignored
        drive(1, 4'd5, 10, "hold5");
        drive(1, 4'd3, 10, "hold3");
        check_int("hold_numero", int'(numero), 5);
        drive(0, 4'd3, 10, "hold_rel");
        drive(1, 4'd3, 10, "press3");
        check_int("press3_numero", int'(numero), 3);
        drive(0, 4'd3, 10, "rel3");

        // Non-BCD digit
        pulses = 0;
        drive(1, 4'd12, 10, "d12");
        drive(0, 4'd12, 10, "d12_rel");
`ifdef CONDICIONADOR_FILTRO_BCD_EN
        check_int("d12_pulses", pulses, 0);
        check_int("d12_erro", int'(erro_bcd), 1);
        check_int("d12_numero", int'(numero), 3);
`else
        check_int("d12_pulses", pulses, 1);
        check_int("d12_numero", int'(numero), 12);
`endif
        pulses = 0;
        drive(1, 4'd9, 10, "d9");
        drive(0, 4'd9, 10, "d9_rel");
        check_int("d9_pulses", pulses, 1);
        check_int("d9_numero", int'(numero), 9);
        check_int("d9_erro", int'(erro_bcd), 0);

        // Reset in the middle of the press filter
        botao_insere = 1'b1; chaves_numero = 4'd7;
        repeat (4) step("mid_filter");
        #2;
        async_reset("mid_reset");
        check_int("mid_reset_ocupado", int'(ocupado), 0);
        check_int("mid_reset_numero", int'(numero), 0);
        repeat (2) step("mid_reset_hold");
        reset = 1'b0;
        pulses = 0; first = 0;
        for (int k = 1; k <= 15; k++) begin
            step("post_reset");
            if (insere === 1'b1 && first == 0) first = k;
        end
        check_int("post_reset_edge", first, 7);
        check_int("post_reset_pulses", pulses, 1);
        check_int("post_reset_numero", int'(numero), 7);
        drive(0, 4'd7, 10, "post_reset_rel");

        // Randomized bouncing segments with occasional resets
        for (int i = 0; i < 300; i++) begin
            botao_insere  = 1'($urandom_range(0, 1));
            chaves_numero = 4'($urandom);
            repeat ($urandom_range(1, 12)) begin
                step("rand");
                if ($urandom_range(0, 7) == 0) chaves_numero = 4'($urandom);
            end
            if ($urandom_range(0, 39) == 0) begin
                async_reset("rand_reset");
                repeat ($urandom_range(1, 2)) step("rand_reset_hold");
                reset = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/condicionador_entrada.md
CONDICIONADOR_ENTRADA -- requirements
Module: condicionador_entrada

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 16: consecutive synchronized samples required to accept a press or a release; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 botao_insere  input  1  raw push-button, asynchronous to clk, bouncing.
REQ-005 chaves_numero  input  4  raw track-digit switches, asynchronous to clk.
REQ-006 insere  output  1  one-cycle pulse per accepted press; feeds the downstream track-state FSM insere input.
REQ-007 numero  output  4  registered digit captured at the accepted press; feeds the downstream numero input.
REQ-008 ocupado  output  1  high whenever the FSM is not in OCIOSO.
REQ-009 erro_bcd  output  1  non-BCD digit rejected (see Configuration).

Function
REQ-010 botao_insere and each chaves_numero bit SHALL pass through a 2-flop synchronizer; botao_s and chaves_s denote the second-flop outputs.
REQ-011 FSM states: OCIOSO, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA; counter cnt has width clog2(DEBOUNCE_CICLOS).
REQ-012 OCIOSO: botao_s=1 -> FILTRA_PRESS with cnt=0; otherwise stay in OCIOSO.
REQ-013 FILTRA_PRESS: botao_s=0 -> OCIOSO; botao_s=1 with cnt<DEBOUNCE_CICLOS-1 -> cnt+1; botao_s=1 with cnt=DEBOUNCE_CICLOS-1 -> PRESSIONADO and accept.
REQ-014 Accept: on the same edge, insere<=1 for exactly one cycle and numero<=chaves_s.
REQ-015 Latency: insere is high after the (DEBOUNCE_CICLOS+3)-th rising edge, counting the first edge that samples botao_insere high, given the input stays high throughout.
REQ-016 PRESSIONADO: botao_s=0 -> FILTRA_SOLTA with cnt=0. A held button SHALL produce no further pulses (no auto-repeat).
REQ-017 FILTRA_SOLTA: botao_s=1 -> PRESSIONADO, with no pulse; DEBOUNCE_CICLOS consecutive low samples -> OCIOSO.
REQ-018 numero SHALL hold its value between accepts. Switch changes outside an accept edge SHALL have no effect.
REQ-019 insere SHALL never be high on two consecutive cycles, and SHALL never be high outside the FILTRA_PRESS->PRESSIONADO transition.

Reset
REQ-020 When reset is asserted: state=OCIOSO, cnt=0, synchronizer flops=0, insere=0, numero=0, ocupado=0, erro_bcd=0, all immediately and without a clock edge.
REQ-021 Reset asserted mid-filter SHALL abort the filter. A button still held after reset deasserts SHALL be re-filtered from zero and yield exactly one pulse.

Configuration
REQ-022 Macro CONDICIONADOR_FILTRO_BCD_EN, defined: at an accept edge with chaves_s>9, insere stays 0, numero is unchanged, erro_bcd<=1 and the FSM still enters PRESSIONADO.
REQ-023 With the macro defined, erro_bcd SHALL stay 1 until the next valid accept (cleared on that edge) or reset.
REQ-024 Macro undefined: all 16 digit values are accepted and erro_bcd is tied to 0.

Verification (DEBOUNCE_CICLOS=4)
REQ-025 Reset, then botao_insere high for 20 cycles with chaves=5 -> one insere pulse after edge 7, numero=5, no second pulse.
REQ-026 botao_insere high for 3 cycles, then low -> insere never asserted, numero unchanged, ocupado returns to 0.
REQ-027 Accepted press, then release bounce low2/high1/low10, then a clean press with chaves=6 -> exactly two pulses total, numero=6.
REQ-028 After an accept with chaves=5, change chaves to 3 while held -> numero stays 5 until the next accepted press.
REQ-029 Press with chaves=12 -> macro defined: no pulse and erro_bcd=1, then a press with chaves=9 gives a pulse, numero=9, erro_bcd=0; macro undefined: pulse with numero=12.
REQ-030 Assert reset during FILTRA_PRESS with the button held -> outputs go to 0 at once; after deassert, one pulse after edge 7 counted from the first post-reset edge.
